// File: rtl/decode_stage.sv
// decode_stage: instruction decode with ID/EX pipeline register.
//
// Sits between fetch and execute. It drives the register file read addresses
// and samples the asynchronous read data. A write-back to the same register in
// the same cycle is bypassed. Two-word (immediate/load) instructions are
// assembled here. Decode stalls on a load-use hazard and squashes on a flush.
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   if_valid, if_instr         fetched word ([15:11] opcode, [10:8] dst, [7:5] src)
//   if_ready                   word consumed at this edge when if_valid & if_ready
//   rf_dst_addr, rf_src_addr   register file read addresses
//   rf_data1, rf_data2         asynchronous register file read data
//   wb_en, wb_addr, wb_data    write-back port, same cycle as the register file write
//   ex_load_pending/addr       load currently in EX and its destination
//   flush                      squash decode (taken branch)
//   id_*                       ID/EX pipeline register contents
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    output logic        if_ready,
    output logic [2:0]  rf_dst_addr,
    output logic [2:0]  rf_src_addr,
    input  logic [15:0] rf_data1,
    input  logic [15:0] rf_data2,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    input  logic        ex_load_pending,
    input  logic [2:0]  ex_load_addr,
    input  logic        flush,
    output logic        id_valid,
    output logic [4:0]  id_opcode,
    output logic [2:0]  id_dst,
    output logic [2:0]  id_src,
    output logic [15:0] id_op1,
    output logic [15:0] id_op2,
    output logic [15:0] id_imm,
    output logic        id_wb_en,
    output logic        id_is_load
);

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  opcode;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] imm;
        logic        wb_en;
        logic        is_load;
    } idex_t;

    state_t      state_q, state_d;
    // Only the opcode/dst/src bits of a held opcode word are ever used, so
    // the low five bits are not stored.
    logic [15:5] hold_q, hold_d;
    idex_t       idex_q, idex_d;

    logic [15:5] rd_instr;
    logic [15:0] op1_s, op2_s;
    logic        hazard;

    // Read addresses, bypass and hazard detection
    always_comb begin
        rd_instr    = (state_q == S_IMM) ? hold_q : if_instr[15:5];
        rf_dst_addr = rd_instr[10:8];
        rf_src_addr = rd_instr[7:5];

        op1_s = (wb_en && (wb_addr == rf_dst_addr)) ? wb_data : rf_data1;
        op2_s = (wb_en && (wb_addr == rf_src_addr)) ? wb_data : rf_data2;

        hazard = ex_load_pending &&
                 ((ex_load_addr == rf_dst_addr) || (ex_load_addr == rf_src_addr));

        if_ready = !flush && !hazard;
    end

    // Next state; ID/EX defaults to a bubble
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idex_d  = '0;

        if (flush) begin
            state_d = S_OP;
            hold_d  = '0;
        end else if (hazard) begin
            // stall: keep state and held opcode, emit bubble
        end else if (if_valid) begin
            if ((state_q == S_OP) && if_instr[15]) begin
                hold_d  = if_instr[15:5];
                state_d = S_IMM;
            end else begin
                // rd_instr is the instruction being issued in both the
                // one-word and the completing two-word case.
                idex_d.valid   = 1'b1;
                idex_d.opcode  = rd_instr[15:11];
                idex_d.dst     = rd_instr[10:8];
                idex_d.src     = rd_instr[7:5];
                idex_d.op1     = op1_s;
                idex_d.op2     = op2_s;
                idex_d.imm     = (state_q == S_IMM) ? if_instr : '0;
                idex_d.wb_en   = (rd_instr[15:14] != 2'b01) && (rd_instr[15:11] != 5'h00);
                idex_d.is_load = (rd_instr[15:14] == 2'b11);
                state_d        = S_OP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_OP;
            hold_q  <= '0;
            idex_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idex_q  <= idex_d;
        end
    end

    assign id_valid   = idex_q.valid;
    assign id_opcode  = idex_q.opcode;
    assign id_dst     = idex_q.dst;
    assign id_src     = idex_q.src;
    assign id_op1     = idex_q.op1;
    assign id_op2     = idex_q.op2;
    assign id_imm     = idex_q.imm;
    assign id_wb_en   = idex_q.wb_en;
    assign id_is_load = idex_q.is_load;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: table of per-cycle stimulus with expected
// if_ready and expected ID/EX contents, plus hand-written reset sequences.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        if_ready;
    logic [2:0]  rf_dst_addr;
    logic [2:0]  rf_src_addr;
    logic [15:0] rf_data1;
    logic [15:0] rf_data2;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_load_pending;
    logic [2:0]  ex_load_addr;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_opcode;
    logic [2:0]  id_dst;
    logic [2:0]  id_src;
    logic [15:0] id_op1;
    logic [15:0] id_op2;
    logic [15:0] id_imm;
    logic        id_wb_en;
    logic        id_is_load;

    decode_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_ready        (if_ready),
        .rf_dst_addr     (rf_dst_addr),
        .rf_src_addr     (rf_src_addr),
        .rf_data1        (rf_data1),
        .rf_data2        (rf_data2),
        .wb_en           (wb_en),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .ex_load_pending (ex_load_pending),
        .ex_load_addr    (ex_load_addr),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_dst          (id_dst),
        .id_src          (id_src),
        .id_op1          (id_op1),
        .id_op2          (id_op2),
        .id_imm          (id_imm),
        .id_wb_en        (id_wb_en),
        .id_is_load      (id_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Static register file model: R[i] = 16'h1000 + i, except R2 = 16'h0007
    logic [15:0] rf_mem [8];
    assign rf_data1 = rf_mem[rf_dst_addr];
    assign rf_data2 = rf_mem[rf_src_addr];

    typedef struct packed {
        logic        rst_n;
        logic        valid;
        logic [15:0] instr;
        logic        flush;
        logic        ldp;
        logic [2:0]  lda;
        logic        wben;
        logic [2:0]  wba;
        logic [15:0] wbd;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  opc;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] imm;
        logic        wb;
        logic        ld;
    } exp_t;

    typedef struct packed {
        stim_t s;
        logic  rdy;
        exp_t  e;
    } vec_t;

    int    checks;
    int    errors;
    exp_t  sb_q [$];
    vec_t  tbl  [$];

    function automatic stim_t S(input logic rst, input logic v, input logic [15:0] ins,
                                input logic fl, input logic ldp, input logic [2:0] lda,
                                input logic we, input logic [2:0] wa, input logic [15:0] wd);
        stim_t r;
        r.rst_n = rst; r.valid = v; r.instr = ins; r.flush = fl;
        r.ldp = ldp; r.lda = lda; r.wben = we; r.wba = wa; r.wbd = wd;
        return r;
    endfunction

    function automatic exp_t E(input logic [4:0] o, input logic [2:0] d, input logic [2:0] sr,
                               input logic [15:0] a, input logic [15:0] b, input logic [15:0] i,
                               input logic w, input logic l);
        exp_t r;
        r.valid = 1'b1; r.opc = o; r.dst = d; r.src = sr;
        r.op1 = a; r.op2 = b; r.imm = i; r.wb = w; r.ld = l;
        return r;
    endfunction

    function automatic vec_t V(input stim_t s, input logic rdy, input exp_t e);
        vec_t r;
        r.s = s; r.rdy = rdy; r.e = e;
        return r;
    endfunction

    // Plain valid word, no side conditions
    function automatic stim_t W(input logic [15:0] ins);
        return S(1'b1, 1'b1, ins, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
    endfunction

    localparam exp_t BUB = '0;

    task automatic run(input stim_t s, input logic rdy, input exp_t e, input string nm);
        exp_t got;
        exp_t want;
        @(negedge clk);
        rst_n           = s.rst_n;
        if_valid        = s.valid;
        if_instr        = s.instr;
        flush           = s.flush;
        ex_load_pending = s.ldp;
        ex_load_addr    = s.lda;
        wb_en           = s.wben;
        wb_addr         = s.wba;
        wb_data         = s.wbd;
        #1;
        checks++;
        if (if_ready !== rdy) begin
            errors++;
            $display("FAIL %s if_ready: got %b want %b", nm, if_ready, rdy);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = {id_valid, id_opcode, id_dst, id_src, id_op1, id_op2, id_imm, id_wb_en, id_is_load};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s id: scoreboard empty", nm);
        end else begin
            want = sb_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL %s id: got v=%b opc=%h dst=%0d src=%0d op1=%h op2=%h imm=%h wb=%b ld=%b want v=%b opc=%h dst=%0d src=%0d op1=%h op2=%h imm=%h wb=%b ld=%b",
                         nm, got.valid, got.opc, got.dst, got.src, got.op1, got.op2, got.imm, got.wb, got.ld,
                         want.valid, want.opc, want.dst, want.src, want.op1, want.op2, want.imm, want.wb, want.ld);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8; i++) rf_mem[i] = 16'h1000 + 16'(i);
        rf_mem[2] = 16'h0007;

        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; flush = 1'b0;
        ex_load_pending = 1'b0; ex_load_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        // Reset held two cycles with a valid word present
        run(S(1'b0, 1'b1, 16'h0B20, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0), 1'b1, BUB, "reset0");
        run(S(1'b0, 1'b1, 16'h0B20, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0), 1'b1, BUB, "reset1");

        // One-word ALU: opcode 01, dst 3, src 1
        tbl.push_back(V(W(16'h0B20), 1'b1, E(5'h01, 3'd3, 3'd1, 16'h1003, 16'h1001, 16'h0, 1'b1, 1'b0)));
        // Two-word immediate: opcode 10, dst 5, then 1234
        tbl.push_back(V(W(16'h8500), 1'b1, BUB));
        tbl.push_back(V(W(16'h1234), 1'b1, E(5'h10, 3'd5, 3'd0, 16'h1005, 16'h1000, 16'h1234, 1'b1, 1'b0)));
        // Bypass on operand 1 (dst 2, src 3)
        tbl.push_back(V(S(1'b1, 1'b1, 16'h1260, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 16'h00FF), 1'b1,
                        E(5'h02, 3'd2, 3'd3, 16'h00FF, 16'h1003, 16'h0, 1'b1, 1'b0)));
        // Same address but wb_en low: register file value
        tbl.push_back(V(S(1'b1, 1'b1, 16'h1260, 1'b0, 1'b0, 3'd0, 1'b0, 3'd2, 16'h00FF), 1'b1,
                        E(5'h02, 3'd2, 3'd3, 16'h0007, 16'h1003, 16'h0, 1'b1, 1'b0)));
        // NOP with bypass on operand 2: wb_en stays 0
        tbl.push_back(V(S(1'b1, 1'b1, 16'h0060, 1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 16'hBEEF), 1'b1,
                        E(5'h00, 3'd0, 3'd3, 16'h1000, 16'hBEEF, 16'h0, 1'b0, 1'b0)));
        // Store class: opcode 08, no write-back
        tbl.push_back(V(W(16'h4140), 1'b1, E(5'h08, 3'd1, 3'd2, 16'h1001, 16'h0007, 16'h0, 1'b0, 1'b0)));
        // Load-use on src 4: two stalled cycles, then issue
        tbl.push_back(V(S(1'b1, 1'b1, 16'h1980, 1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0), 1'b0, BUB));
        tbl.push_back(V(S(1'b1, 1'b1, 16'h1980, 1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0), 1'b0, BUB));
        tbl.push_back(V(W(16'h1980), 1'b1, E(5'h03, 3'd1, 3'd4, 16'h1001, 16'h1004, 16'h0, 1'b1, 1'b0)));
        // Load-use on dst 1
        tbl.push_back(V(S(1'b1, 1'b1, 16'h1980, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 16'h0), 1'b0, BUB));
        // Pending load to an unrelated register: no stall
        tbl.push_back(V(S(1'b1, 1'b1, 16'h1980, 1'b0, 1'b1, 3'd7, 1'b0, 3'd0, 16'h0), 1'b1,
                        E(5'h03, 3'd1, 3'd4, 16'h1001, 16'h1004, 16'h0, 1'b1, 1'b0)));
        // No valid word: bubble
        tbl.push_back(V(S(1'b1, 1'b0, 16'h0B20, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0), 1'b1, BUB));
        // Flush in S_IMM discards the held load; next word is an opcode
        tbl.push_back(V(W(16'hC300), 1'b1, BUB));
        tbl.push_back(V(S(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0), 1'b0, BUB));
        tbl.push_back(V(W(16'h0920), 1'b1, E(5'h01, 3'd1, 3'd1, 16'h1001, 16'h1001, 16'h0, 1'b1, 1'b0)));
        // Complete load: opcode 18, dst 3
        tbl.push_back(V(W(16'hC300), 1'b1, BUB));
        tbl.push_back(V(W(16'hABCD), 1'b1, E(5'h18, 3'd3, 3'd0, 16'h1003, 16'h1000, 16'hABCD, 1'b1, 1'b1)));
        // Hazard in S_IMM is checked against the held dst (5), not if_instr
        tbl.push_back(V(W(16'h8500), 1'b1, BUB));
        tbl.push_back(V(S(1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 3'd5, 1'b0, 3'd0, 16'h0), 1'b0, BUB));
        tbl.push_back(V(W(16'h4321), 1'b1, E(5'h10, 3'd5, 3'd0, 16'h1005, 16'h1000, 16'h4321, 1'b1, 1'b0)));
        // Flush and hazard together in S_IMM: flush wins, back to S_OP
        tbl.push_back(V(W(16'hC300), 1'b1, BUB));
        tbl.push_back(V(S(1'b1, 1'b1, 16'h0920, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 16'h0), 1'b0, BUB));
        tbl.push_back(V(W(16'h0920), 1'b1, E(5'h01, 3'd1, 3'd1, 16'h1001, 16'h1001, 16'h0, 1'b1, 1'b0)));

        foreach (tbl[i]) run(tbl[i].s, tbl[i].rdy, tbl[i].e, $sformatf("row%0d", i));

        // Reset mid-operation: held opcode dropped, next word is an opcode
        run(W(16'h0B20), 1'b1, E(5'h01, 3'd3, 3'd1, 16'h1003, 16'h1001, 16'h0, 1'b1, 1'b0), "mid_a");
        run(W(16'h8500), 1'b1, BUB, "mid_b");
        run(S(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0), 1'b1, BUB, "mid_rst");
        run(W(16'h0B20), 1'b1, E(5'h01, 3'd3, 3'd1, 16'h1003, 16'h1001, 16'h0, 1'b1, 1'b0), "mid_c");

        // Reset clears a valid ID/EX entry
        run(S(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0), 1'b1, BUB, "rst_clr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage with ID/EX pipeline register. It sits between fetch and execute and drives the register file read addresses. It samples the register file's asynchronous read data and bypasses a same-cycle write-back. It assembles two-word (immediate) instructions, stalls on load-use hazards and squashes on flush.

## Interface
Parameters:
- none (fixed 16-bit datapath, 8 registers)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  reset; one clock, synchronous, active-low
- if_valid  in  1  fetch presents a valid word on if_instr
- if_instr  in  16  instruction or immediate word; [15:11] opcode, [10:8] dst, [7:5] src
- if_ready  out  1  word consumed at this edge when if_valid & if_ready
- rf_dst_addr  out  3  register file read address for operand 1 (dst field)
- rf_src_addr  out  3  register file read address for operand 2 (src field)
- rf_data1  in  16  register file data at rf_dst_addr (async)
- rf_data2  in  16  register file data at rf_src_addr (async)
- wb_en  in  1  write-back writing this cycle (same signal driving the register file)
- wb_addr  in  3  write-back register address
- wb_data  in  16  write-back data
- ex_load_pending  in  1  instruction currently in EX is a load
- ex_load_addr  in  3  destination of that load
- flush  in  1  squash decode (taken branch)
- id_valid  out  1  ID/EX holds a real instruction
- id_opcode  out  5
- id_dst  out  3
- id_src  out  3
- id_op1  out  16  operand 1 (dst register value)
- id_op2  out  16  operand 2 (src register value)
- id_imm  out  16  immediate word; 0 for one-word instructions
- id_wb_en  out  1  instruction writes the register file
- id_is_load  out  1  instruction is a memory load

## Operation
Opcode classes, by opcode[4:3]:
- 00: ALU, one word. id_wb_en=1, except opcode 5'h00 (NOP), which has id_wb_en=0.
- 01: store/branch/out, one word. id_wb_en=0.
- 10: immediate, two words. id_wb_en=1.
- 11: load, two words. id_wb_en=1, id_is_load=1.

Held instruction register: hold_instr, 16 bits.

States:
- S_OP: expecting an opcode word.
- S_IMM: expecting the immediate word of a held two-word instruction.

Read address source:
- S_OP: fields of if_instr.
- S_IMM: fields of hold_instr.

Operand bypass (per operand):
- If wb_en and wb_addr equals the read address, the sampled value is wb_data.
- Otherwise the sampled value is rf_data1 / rf_data2.

Hazard:
- hazard = ex_load_pending & (ex_load_addr == read dst | ex_load_addr == read src).
- It is evaluated against the current read addresses, for every class including NOP.

if_ready = !flush & !hazard (combinational).

Transitions at the edge, priority top-down:
1. rst_n=0: state S_OP; hold_instr=0; all id_* outputs=0.
2. flush=1: state S_OP; hold_instr=0; ID/EX loads a bubble; the word is not consumed.
3. hazard: state unchanged; hold_instr unchanged; ID/EX loads a bubble.
4. S_OP, if_valid, two-word opcode: hold_instr←if_instr; go to S_IMM; ID/EX loads a bubble.
5. S_OP, if_valid, one-word opcode: ID/EX←decoded fields plus sampled operands; id_imm=0; id_valid=1.
6. S_IMM, if_valid: ID/EX←hold_instr fields plus operands sampled now; id_imm=if_instr; id_valid=1; go to S_OP.
7. No if_valid: ID/EX loads a bubble; state and hold_instr unchanged.

Bubble definition:
- id_valid=0, id_wb_en=0, id_is_load=0.
- Other id_* fields are 0.

## Timing
- Reset values: every id_* output is 0; state S_OP; if_ready=1 unless flush or hazard is asserted.
- Latency:
  - One-word instruction: one cycle from the accepting edge to id_valid.
  - Two-word instruction: id_valid after the immediate word's accepting edge.
- Operands for a two-word instruction are sampled when the immediate word is accepted, not when the opcode word is accepted.
- Bypass is combinational, so a write at the same edge as decode is seen. Sequence: WB writes R3 at edge N; decode of R3 also samples at edge N; id_op gets wb_data.
- A load-use stall lasts exactly as long as ex_load_pending matches; ID/EX outputs a bubble each stalled cycle.
- A flush during S_IMM discards the held opcode; the next word is treated as an opcode.
- Flush and hazard together: flush wins.
- Reset mid-operation: the state returns to S_IMM→S_OP next edge; no partial instruction is emitted.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with if_valid=1 → all id_*=0 and state S_OP. Release reset → first word 16'h0B20 (opcode 01, dst 3, src 1) gives id_valid=1, id_opcode=5'h01, id_dst=3, id_src=1, id_wb_en=1 one cycle later.
- Two-word: send 16'h8500 (opcode 10, dst 5) then 16'h1234 → first cycle id_valid=0; next cycle id_valid=1, id_imm=16'h1234, id_dst=5, id_wb_en=1.
- Bypass: R2=16'h0007 in the register file; wb_en=1, wb_addr=2, wb_data=16'h00FF in the same cycle as decoding dst=2 → id_op1=16'h00FF.
- Load-use: ex_load_pending=1, ex_load_addr=4; decode a word with src=4 → if_ready=0 and id_valid=0 for 2 cycles while pending is held. Deassert pending → the instruction issues the next cycle.
- Flush in S_IMM: send 16'hC300 (load), then assert flush → id_valid=0; the next word 16'h0920 decodes as opcode 01, not as an immediate.
- Flush during hazard: assert both → if_ready=0; state goes to S_OP; id_valid=0.
